// File: rtl/binary_to_ternary_converter_pkg.sv
// Shared constants for the binary-to-ternary converter: trit codes, FSM encoding,
// and the step-counter width helper.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO    = 2'b00;
  localparam logic [1:0] TRIT_ONE     = 2'b01;
  localparam logic [1:0] TRIT_TWO     = 2'b10;
  localparam logic [1:0] TRIT_INVALID = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CONV = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Width of a counter indexing TRITS digits; never narrower than one bit.
  function automatic int unsigned step_w(int unsigned trits);
    return (trits <= 1) ? 1 : $clog2(trits);
  endfunction

endpackage

// File: rtl/binary_to_ternary_converter_if.sv
// Valid/ready operand and result bundle between a producer/consumer (master) and the
// converter (slave).
interface binary_to_ternary_converter_if #(
  parameter int unsigned BIN_W = 8,
  parameter int unsigned TRITS = 6
);

  logic               inValid;
  logic               inReady;
  logic [BIN_W-1:0]   inBin;
  logic               outValid;
  logic               outReady;
  logic [2*TRITS-1:0] outTrits;
  logic               ovf;
  logic               busy;

  modport master (
    output inValid, inBin, outReady,
    input  inReady, outValid, outTrits, ovf, busy
  );

  modport slave (
    input  inValid, inBin, outReady,
    output inReady, outValid, outTrits, ovf, busy
  );

endinterface

// File: rtl/binary_to_ternary_converter_div3_step.sv
// Combinational divide-by-3: restoring chain MSb first, remainder r = (2r + b) mod 3.
module div3_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] in,
  output logic [W-1:0] quot,
  output logic [1:0]   rem
);

  logic [2:0] t;
  logic [1:0] r;

  always_comb begin
    t    = '0;
    r    = '0;
    quot = '0;
    for (int i = W - 1; i >= 0; i--) begin
      t = {r, in[i]};
      if (t >= 3'd3) begin
        quot[i] = 1'b1;
        r       = 2'(t - 3'd3);
      end else begin
        r = t[1:0];
      end
    end
    rem = r;
  end

endmodule

// File: rtl/binary_to_ternary_converter.sv
// Sequential binary-to-ternary converter, one digit per clock, LS digit first.
// Define B2T_EARLY_EXIT_EN to finish as soon as the quotient reaches zero.
module binary_to_ternary_converter
  import ternary_pkg::*;
#(
  parameter int unsigned BIN_W = 8,
  parameter int unsigned TRITS = 6
) (
  input logic                         clk,
  input logic                         resetN,
  binary_to_ternary_converter_if.slave bus
);

  localparam int unsigned StepW = step_w(TRITS);

  logic [1:0]         state_q, state_d;
  logic [BIN_W-1:0]   q_q, q_d;
  logic [2*TRITS-1:0] digits_q, digits_d;
  logic [StepW-1:0]   step_q, step_d;
  logic               ovf_q, ovf_d;

  logic [BIN_W-1:0]   quot;
  logic [1:0]         rem;
  logic               accept;

  div3_step #(
    .W (BIN_W)
  ) u_div3_step (
    .in   (q_q),
    .quot (quot),
    .rem  (rem)
  );

  // Gated by resetN so no operand is taken during the reset cycle.
  assign bus.inReady  = resetN & ((state_q == ST_IDLE) |
                                  ((state_q == ST_DONE) & bus.outReady));
  assign accept       = bus.inValid & bus.inReady;
  assign bus.outValid = (state_q == ST_DONE);
  assign bus.busy     = (state_q == ST_CONV);
  assign bus.outTrits = digits_q;
  assign bus.ovf      = ovf_q;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    digits_d = digits_q;
    step_d   = step_q;
    ovf_d    = ovf_q;
    if (accept) begin
      q_d      = bus.inBin;
      digits_d = '0;
      step_d   = '0;
      ovf_d    = 1'b0;
      state_d  = ST_CONV;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_CONV: begin
          q_d    = quot;
          step_d = step_q + StepW'(1);
          for (int k = 0; k < TRITS; k++) begin
            if (step_q == StepW'(k)) digits_d[2*k +: 2] = rem;
          end
          if (step_q == StepW'(TRITS - 1)) begin
            state_d = ST_DONE;
            ovf_d   = (quot != '0);
          end
`ifdef B2T_EARLY_EXIT_EN
          // Remaining digits were cleared on accept, so they already read as zero.
          else if (quot == '0) begin
            state_d = ST_DONE;
            ovf_d   = 1'b0;
          end
`else
`endif
        end
        ST_DONE: begin
          if (bus.outReady) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      digits_q <= '0;
      step_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      digits_q <= digits_d;
      step_q   <= step_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_binary_to_ternary_converter.sv
// Self-checking bench: arithmetic reference model plus per-cycle compare process.
module tb_binary_to_ternary_converter;
  import ternary_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  binary_to_ternary_converter_if #(.BIN_W(8), .TRITS(6)) bus ();
  binary_to_ternary_converter_if #(.BIN_W(10), .TRITS(6)) bus10 ();

  binary_to_ternary_converter #(.BIN_W(8), .TRITS(6)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  binary_to_ternary_converter #(.BIN_W(10), .TRITS(6)) dut10 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus10)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: repeated division of the integer value, plus overflow against 3^6.
  function automatic logic [12:0] model(input int unsigned v);
    int unsigned x = v;
    logic [11:0] d = '0;
    for (int k = 0; k < 6; k++) begin
      d[2*k +: 2] = 2'(x % 3);
      x = x / 3;
    end
    return {(v >= 729) ? 1'b1 : 1'b0, d};
  endfunction

  function automatic int exp_lat(input int unsigned v);
`ifdef B2T_EARLY_EXIT_EN
    int n = 0;
    int unsigned x = v;
    while (x != 0) begin
      n++;
      x = x / 3;
    end
    if (n < 1) n = 1;
    if (n > 6) n = 6;
    return n + 1;
`else
    return 7;
`endif
  endfunction

  typedef struct {
    logic [11:0] d;
    logic        o;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] log_d[$];
  int          cyc = 0;
  int          xfers = 0;
  logic [11:0] last_d = '0;
  logic        last_o = 1'b0;
  bit          acc_in_done = 1'b0;

  // Compare process: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit          valid_exp;
    bit          busy_exp;
    logic [12:0] m;
    cyc++;
    if (!resetN) begin
      check("inReady_in_reset", bus.inReady, 0);
      expq.delete();
    end else begin
      valid_exp = (expq.size() > 0) && (cyc >= expq[0].acc + expq[0].lat);
      busy_exp  = (expq.size() > 0) && !valid_exp;
      check("outValid", bus.outValid, valid_exp);
      check("busy", bus.busy, busy_exp);
      check("inReady", bus.inReady, !busy_exp && (!valid_exp || bus.outReady));
      if (valid_exp) begin
        check("outTrits", bus.outTrits, expq[0].d);
        check("ovf", bus.ovf, expq[0].o);
        for (int k = 0; k < 6; k++)
          if (bus.outTrits[2*k +: 2] == TRIT_INVALID) check("trit_code", 2'b11, 2'b00);
        if (bus.outReady) begin
          last_d = expq[0].d;
          last_o = expq[0].o;
          log_d.push_back(expq[0].d);
          xfers++;
          void'(expq.pop_front());
        end
      end
      if (bus.inValid && bus.inReady) begin
        m = model(int'(bus.inBin));
        acc_in_done = valid_exp;
        expq.push_back('{d: m[11:0], o: m[12], acc: cyc, lat: exp_lat(int'(bus.inBin))});
      end
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.inReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned v);
    @(posedge clk);
    #1;
    bus.inValid = 1'b1;
    bus.inBin   = 8'(v);
    wait_accept();
    bus.inValid = 1'b0;
  endtask

  task automatic wait_xfer(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (xfers >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("xfer_timeout", 0, 1);
    #1;
  endtask

  task automatic send10(input int unsigned v, input logic [11:0] exp_d, input logic exp_o);
    bit ok = 1'b0;
    int lat = 0;
    @(posedge clk);
    #1;
    bus10.inValid = 1'b1;
    bus10.inBin   = 10'(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus10.inReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("w10_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus10.inValid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (bus10.outValid) begin
        ok = 1'b1;
        break;
      end
    end
    check("w10_valid_timeout", ok, 1);
    check("w10_latency", lat, 7);
    check("w10_outTrits", bus10.outTrits, exp_d);
    check("w10_ovf", bus10.ovf, exp_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int x0;
    int unsigned vals[$];
    bus.inValid    = 1'b0;
    bus.inBin      = '0;
    bus.outReady   = 1'b0;
    bus10.inValid  = 1'b0;
    bus10.inBin    = '0;
    bus10.outReady = 1'b1;

    // Pin the reference model against hand-computed values.
    check("model_255", model(255), {1'b0, 12'b01_00_00_01_01_00});
    check("model_100", model(100), {1'b0, 12'b00_01_00_10_00_01});
    check("model_7", model(7), {1'b0, 12'b00_00_00_00_10_01});
    check("model_13", model(13), {1'b0, 12'b00_00_00_01_01_01});
    check("model_729", model(729), {1'b1, 12'b0});
    check("model_728", model(728), {1'b0, 12'b10_10_10_10_10_10});

    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;

    // Reset mid-conversion discards the operand.
    bus.outReady = 1'b1;
    x0 = xfers;
    send(200);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(negedge clk);
    check("t1_outValid", bus.outValid, 0);
    check("t1_inReady", bus.inReady, 1);
    check("t1_discarded", xfers, x0);
    send(5);
    wait_xfer(x0 + 1);
    check("t1_result5", last_d, 12'b0000_0000_0110);
    check("t1_ovf5", last_o, 0);

    // Maximum 8-bit operand.
    send(255);
    wait_xfer(x0 + 2);
    check("t2_result255", last_d, 12'b01_00_00_01_01_00);
    check("t2_ovf255", last_o, 0);

    // Backpressure: result held until the consumer accepts it, exactly once.
    bus.outReady = 1'b0;
    x0 = xfers;
    send(100);
    for (int i = 0; i < 50 && !bus.outValid; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("t3_held_valid", bus.outValid, 1);
    check("t3_held_trits", bus.outTrits, 12'b00_01_00_10_00_01);
    check("t3_inReady", bus.inReady, 0);
    check("t3_no_xfer", xfers, x0);
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    bus.outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_single_xfer", xfers, x0 + 1);
    check("t3_dropped", bus.outValid, 0);
    bus.outReady = 1'b1;

    // Back-to-back: second operand accepted on the transfer edge.
    x0 = xfers;
    @(posedge clk);
    #1;
    bus.inValid = 1'b1;
    bus.inBin   = 8'd7;
    wait_accept();
    bus.inBin = 8'd13;
    wait_accept();
    check("t4_accept_in_done", acc_in_done, 1);
    bus.inValid = 1'b0;
    wait_xfer(x0 + 2);
    check("t4_result7", log_d[log_d.size()-2], 12'b00_00_00_00_10_01);
    check("t4_result13", last_d, 12'b00_00_00_01_01_01);

    // Wider operand: overflow boundary.
    send10(729, 12'b0, 1'b1);
    send10(728, 12'b10_10_10_10_10_10, 1'b0);

    // Small values, digit-count boundaries and a few random operands.
    x0 = xfers;
    send(0);
    wait_xfer(x0 + 1);
    check("t6_zero", last_d, 12'b0);
    send(2);
    wait_xfer(x0 + 2);
    check("t6_two", last_d, 12'b00_00_00_00_00_10);
    vals = '{1, 3, 8, 9, 26, 27, 80, 81, 242, 243, 254};
    for (int i = 0; i < 6; i++) vals.push_back($urandom_range(0, 255));
    foreach (vals[i]) begin
      x0 = xfers;
      send(vals[i]);
      wait_xfer(x0 + 1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
